// File: rtl/handshake_fifo.sv
// First-word-fall-through valid/ready FIFO with registered-only up_ready_o.
// Optional stall counter port stall_cnt_o when HANDSHAKE_FIFO_STATS_EN is defined.
module handshake_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              up_valid_i,
    input  logic [DATA_W-1:0] up_data_i,
    output logic              up_ready_o,
    output logic              dn_valid_o,
    output logic [DATA_W-1:0] dn_data_o,
    input  logic              dn_ready_i,
`ifdef HANDSHAKE_FIFO_STATS_EN
    output logic [15:0]       stall_cnt_o,
`endif
    output logic [CNT_W-1:0]  level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Handshake outputs come only from registered count, so dn_ready_i never reaches up_ready_o.
    assign up_ready_o = (count != FULL_LVL);
    assign dn_valid_o = (count != '0);
    assign dn_data_o  = dn_valid_o ? mem[rd_ptr] : '0;
    assign level_o    = count;

    assign push = up_valid_i & up_ready_o;
    assign pop  = dn_valid_o & dn_ready_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only and is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (rst_n && push)
            mem[wr_ptr] <= up_data_i;
    end

`ifdef HANDSHAKE_FIFO_STATS_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (dn_valid_o && !dn_ready_i)
            stall_cnt <= sat_inc16(stall_cnt);
    end

    assign stall_cnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_handshake_fifo.sv
// Testbench for handshake_fifo: directed vector table, corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_handshake_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              up_valid_i;
    logic [DATA_W-1:0] up_data_i;
    logic              up_ready_o;
    logic              dn_valid_o;
    logic [DATA_W-1:0] dn_data_o;
    logic              dn_ready_i;
    logic [CNT_W-1:0]  level_o;
`ifdef HANDSHAKE_FIFO_STATS_EN
    logic [15:0]       stall_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] mq[$];
    int                m_stall = 0;
    logic [DATA_W-1:0] got[$];

    typedef struct {
        logic              rst_n;
        logic              uv;
        logic [DATA_W-1:0] d;
        logic              dr;
        logic              e_rdy;
        logic              e_vld;
        logic [DATA_W-1:0] e_data;
        logic [CNT_W-1:0]  e_lvl;
    } vec_t;

    vec_t vecs[$];

    handshake_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid_i (up_valid_i),
        .up_data_i  (up_data_i),
        .up_ready_o (up_ready_o),
        .dn_valid_o (dn_valid_o),
        .dn_data_o  (dn_data_o),
        .dn_ready_i (dn_ready_i),
`ifdef HANDSHAKE_FIFO_STATS_EN
        .stall_cnt_o(stall_cnt_o),
`endif
        .level_o    (level_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, actual=running required=done");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input int r, input int uv, input int d, input int dr,
                       input int er, input int ev, input int ed, input int el);
        vec_t v;
        v.rst_n  = r[0];
        v.uv     = uv[0];
        v.d      = d[DATA_W-1:0];
        v.dr     = dr[0];
        v.e_rdy  = er[0];
        v.e_vld  = ev[0];
        v.e_data = ed[DATA_W-1:0];
        v.e_lvl  = el[CNT_W-1:0];
        vecs.push_back(v);
    endtask

    // Reference model: a plain queue, updated from the rules at each rising edge.
    task automatic model_step(input logic r, input logic uv, input logic [DATA_W-1:0] d,
                              input logic dr);
        bit pu;
        bit po;
        if (!r) begin
            mq.delete();
            m_stall = 0;
        end else begin
            pu = uv && (mq.size() < DEPTH);
            po = dr && (mq.size() > 0);
            if (mq.size() > 0 && !dr && m_stall < 65535)
                m_stall++;
            if (po)
                void'(mq.pop_front());
            if (pu)
                mq.push_back(d);
        end
    endtask

    task automatic cycle(input logic r, input logic uv, input logic [DATA_W-1:0] d,
                         input logic dr);
        rst_n      = r;
        up_valid_i = uv;
        up_data_i  = d;
        dn_ready_i = dr;
        #1;
        if (r && dn_valid_o && dr)
            got.push_back(dn_data_o);
        @(posedge clk);
        model_step(r, uv, d, dr);
        #1;
    endtask

    task automatic check_model(input string tag);
        int sz;
        sz = mq.size();
        chk({tag, ".up_ready"}, int'(up_ready_o), int'(sz != DEPTH));
        chk({tag, ".dn_valid"}, int'(dn_valid_o), int'(sz != 0));
        chk({tag, ".dn_data"},  int'(dn_data_o),  (sz != 0) ? int'(mq[0]) : 0);
        chk({tag, ".level"},    int'(level_o),    sz);
`ifdef HANDSHAKE_FIFO_STATS_EN
        chk({tag, ".stall_cnt"}, int'(stall_cnt_o), m_stall);
`endif
    endtask

    initial begin
        rst_n      = 1'b0;
        up_valid_i = 1'b0;
        up_data_i  = '0;
        dn_ready_i = 1'b0;

        //   rst uv  data  dr | rdy vld data lvl
        add(0, 0, 8'h00, 0,   1, 0, 8'h00, 0);
        add(0, 0, 8'h00, 0,   1, 0, 8'h00, 0);
        add(1, 0, 8'h00, 0,   1, 0, 8'h00, 0);
        add(1, 1, 8'hA5, 1,   1, 1, 8'hA5, 1);
        add(1, 0, 8'h00, 1,   1, 0, 8'h00, 0);
        add(1, 1, 8'h01, 0,   1, 1, 8'h01, 1);
        add(1, 1, 8'h02, 0,   1, 1, 8'h01, 2);
        add(1, 1, 8'h03, 0,   1, 1, 8'h01, 3);
        add(1, 1, 8'h04, 0,   0, 1, 8'h01, 4);
        add(1, 1, 8'h05, 0,   0, 1, 8'h01, 4);
        add(1, 1, 8'h05, 1,   1, 1, 8'h02, 3);
        add(1, 1, 8'h05, 0,   0, 1, 8'h02, 4);
        add(1, 0, 8'hEE, 1,   1, 1, 8'h03, 3);
        add(1, 0, 8'h00, 1,   1, 1, 8'h04, 2);
        add(1, 1, 8'h06, 1,   1, 1, 8'h05, 2);
        add(1, 0, 8'h00, 1,   1, 1, 8'h06, 1);
        add(1, 0, 8'h00, 1,   1, 0, 8'h00, 0);
        add(1, 1, 8'h11, 0,   1, 1, 8'h11, 1);
        add(1, 1, 8'h22, 0,   1, 1, 8'h11, 2);
        add(1, 1, 8'h33, 0,   1, 1, 8'h11, 3);
        add(0, 1, 8'h44, 1,   1, 0, 8'h00, 0);
        add(1, 1, 8'h3C, 0,   1, 1, 8'h3C, 1);
        add(1, 0, 8'h00, 1,   1, 0, 8'h00, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].rst_n, vecs[i].uv, vecs[i].d, vecs[i].dr);
            chk($sformatf("vec%0d.up_ready", i), int'(up_ready_o), int'(vecs[i].e_rdy));
            chk($sformatf("vec%0d.dn_valid", i), int'(dn_valid_o), int'(vecs[i].e_vld));
            chk($sformatf("vec%0d.dn_data", i),  int'(dn_data_o),  int'(vecs[i].e_data));
            chk($sformatf("vec%0d.level", i),    int'(level_o),    int'(vecs[i].e_lvl));
        end

        // Pointer wrap: 3*DEPTH beats streamed with concurrent pops.
        got.delete();
        for (int i = 0; i < 3 * DEPTH; i++) begin
            cycle(1'b1, 1'b1, DATA_W'(i), 1'b1);
            check_model("wrap");
        end
        cycle(1'b1, 1'b0, '0, 1'b1);
        check_model("wrap_drain");
        chk("wrap.count", got.size(), 3 * DEPTH);
        for (int i = 0; i < got.size(); i++)
            chk($sformatf("wrap.beat%0d", i), int'(got[i]), i);

`ifdef HANDSHAKE_FIFO_STATS_EN
        cycle(1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b1, 8'h77, 1'b0);
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 1'b0, '0, 1'b0);
        chk("stats.after5", int'(stall_cnt_o), 5);
        cycle(1'b0, 1'b0, '0, 1'b0);
        chk("stats.reset", int'(stall_cnt_o), 0);
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 63) != 0), $urandom_range(0, 1) != 0,
                  DATA_W'($urandom), $urandom_range(0, 2) != 0);
            check_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/handshake_fifo.md
Name: handshake_fifo

Overview:
- Small synchronous valid/ready FIFO that sits directly downstream of the registered-ready handshake stage and consumes its valid/data output.
- Absorbs the one-cycle ready latency of the upstream stage, so no beat is lost when ready deasserts late.
- Presents a first-word-fall-through valid/ready interface to the next consumer.
- No combinational path from dn_ready_i to up_ready_o.

Parameters:
- DATA_W, 8, width of the data payload in bits.
- DEPTH, 4, number of entries; must be a power of 2 and at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count (derived; not to be overridden).

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- up_valid_i  input  1  upstream has a valid beat on up_data_i.
- up_data_i  input  DATA_W  upstream payload.
- up_ready_o  output  1  FIFO can accept a beat this cycle.
- dn_valid_o  output  1  FIFO has a beat on dn_data_o.
- dn_data_o  output  DATA_W  head-of-FIFO payload.
- dn_ready_i  input  1  downstream accepts the beat this cycle.
- level_o  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst_n low at a rising edge): wr_ptr, rd_ptr and count go to 0. Outputs then read up_ready_o=1, dn_valid_o=0, dn_data_o=0, level_o=0. Storage array is not reset.
- Reset mid-operation discards all stored beats. It takes effect at that edge regardless of up_valid_i or dn_ready_i.
- Push = up_valid_i & up_ready_o. Pop = dn_valid_o & dn_ready_i. Both are evaluated at the rising edge.
- up_ready_o = (count != DEPTH). It depends only on registered state.
- dn_valid_o = (count != 0).
- dn_data_o = mem[rd_ptr] when count != 0, else all zeros.
- level_o = count.
- Push: write up_data_i to mem[wr_ptr], then wr_ptr+1. Pop: rd_ptr+1. Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Count update by event:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, both pointers advance.
  - neither: hold.
- Latency: a beat pushed at edge N is visible on dn_valid_o/dn_data_o after edge N (one cycle). There is no same-cycle bypass when empty.
- Full (count=DEPTH): up_ready_o=0 and no push is accepted, even if dn_ready_i=1 that cycle. up_ready_o rises the cycle after the pop.
- Empty (count=0): dn_valid_o=0. dn_ready_i is ignored and no pop occurs.
- Order is strictly FIFO. Data on dn_data_o is stable while dn_valid_o=1 and dn_ready_i=0.
- up_data_i is ignored when up_valid_i=0.
- A beat offered while up_ready_o=0 is not captured. The upstream must hold it (valid/ready rule).

Optional Feature:
- Macro: HANDSHAKE_FIFO_STATS_EN.
- Defined: adds port stall_cnt_o (output, 16 bits).
  - Increments each cycle dn_valid_o=1 and dn_ready_i=0.
  - Saturates at 16'hFFFF.
  - Clears to 0 on synchronous reset.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 with no traffic -> up_ready_o=1, dn_valid_o=0, dn_data_o=0, level_o=0.
- Single beat: push 8'hA5 at edge N with dn_ready_i=1 -> dn_valid_o=1, dn_data_o=8'hA5 after N; popped at N+1; level_o 0→1→0.
- Fill to full: dn_ready_i=0, push 8'h01..8'h04 on consecutive edges -> level_o=4, up_ready_o=0. A fifth beat 8'h05 held valid is not accepted until one pop; after the pop up_ready_o=1 next cycle and 8'h05 enters. Drain order is 01,02,03,04,05.
- Simultaneous push/pop at full and at mid-level (level 2): level_o unchanged at mid-level; at full, only the pop occurs. Pointer wrap over 3×DEPTH beats (incrementing data 0..11) -> output sequence 0..11 with no gaps.
- Reset mid-operation at level_o=3 -> next cycle level_o=0, dn_valid_o=0; subsequent push 8'h3C is the first beat out.
- With HANDSHAKE_FIFO_STATS_EN: hold one beat with dn_ready_i=0 for 5 cycles -> stall_cnt_o=5; reset -> 0.
